// File: rtl/fifo_pkg.sv
// fifo_pkg: definitions shared by the SRL FIFO variants.
//   real_depth()  - storage depth actually built (never below 4 entries)
//   cnt_width()   - width of an occupancy counter covering 0..real depth
//   addr_width()  - width of a storage address covering 0..real depth-1
//   FIFO_CHECK    - elaboration-time parameter guard; use at module level
//                   (generate scope) with a unique block label.

`ifndef FIFO_PKG_MACROS
`define FIFO_PKG_MACROS
`define FIFO_CHECK(lbl, cond, msg) \
  if (!(cond)) begin : lbl \
    $error(msg); \
  end
`endif

package fifo_pkg;

  // Shallower chains leave no room for the almost-full grace window.
  function automatic int real_depth(input int depth);
    return (depth < 4) ? 4 : depth;
  endfunction

  // The counter must hold the value "full", hence the +1.
  function automatic int cnt_width(input int depth);
    return $clog2(real_depth(depth) + 1);
  endfunction

  function automatic int addr_width(input int depth);
    return $clog2(real_depth(depth));
  endfunction

endpackage

// File: rtl/fifo_srl_af_stat_if.sv
// fifo_srl_af_stat_if: producer/consumer bundle of the SRL FIFO.
//   slave  modport - seen by the FIFO (write/read requests in, status out)
//   master modport - seen by the surrounding pipeline (the mirror image)
// Signals:
//   if_write_ce/if_write/if_din  write side request and payload
//   if_read_ce/if_read           read side request
//   if_full_n                    registered almost-full, inverted (advisory)
//   if_empty_n/if_dout           head valid / head data (fall-through)
//   if_almost_empty, if_count    registered occupancy status
//   if_overflow, if_underflow    sticky debug errors

interface fifo_srl_af_stat_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = cnt_width(16)
);

  logic                  if_full_n;
  logic                  if_write_ce;
  logic                  if_write;
  logic [DATA_WIDTH-1:0] if_din;
  logic                  if_empty_n;
  logic                  if_read_ce;
  logic                  if_read;
  logic [DATA_WIDTH-1:0] if_dout;
  logic                  if_almost_empty;
  logic [CNT_WIDTH-1:0]  if_count;
  logic                  if_overflow;
  logic                  if_underflow;

  modport slave (
    input  if_write_ce, if_write, if_din, if_read_ce, if_read,
    output if_full_n, if_empty_n, if_dout, if_almost_empty, if_count,
           if_overflow, if_underflow
  );

  modport master (
    output if_write_ce, if_write, if_din, if_read_ce, if_read,
    input  if_full_n, if_empty_n, if_dout, if_almost_empty, if_count,
           if_overflow, if_underflow
  );

endinterface

// File: rtl/fifo_srl_af_stat_mem.sv
// fifo_srl_af_stat_mem: SRL shift chain used as FIFO storage.
//   clk  - clock
//   ce   - shift enable: data enters entry 0, every entry moves up one
//   data - word shifted in
//   a    - read address (combinational)
//   q    - entry[a]
// Contents are deliberately not reset so the chain maps onto SRL primitives.

module fifo_srl_af_stat_mem
  import fifo_pkg::*;
#(
  parameter      MEM_STYLE = "shiftreg",
  parameter int  WIDTH     = 32,
  parameter int  DEPTH     = 16,
  parameter int  AW        = 4
) (
  input  logic             clk,
  input  logic             ce,
  input  logic [WIDTH-1:0] data,
  input  logic [AW-1:0]    a,
  output logic [WIDTH-1:0] q
);

  // Only shift-register style storage is built here.
  `FIFO_CHECK(g_chk_style, (MEM_STYLE == "shiftreg") || (MEM_STYLE == "auto"),
              "fifo_srl_af_stat_mem: unsupported MEM_STYLE")
  `FIFO_CHECK(g_chk_aw, (1 << AW) >= DEPTH,
              "fifo_srl_af_stat_mem: AW too narrow for DEPTH")

  logic [WIDTH-1:0] sr_q [DEPTH];

  always_ff @(posedge clk) begin
    if (ce) begin
      sr_q[0] <= data;
      for (int i = 1; i < DEPTH; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  // Addresses past the end only occur when DEPTH is not a power of two;
  // the head is never read there, so return zero rather than X.
  assign q = ({1'b0, a} < (AW+1)'(DEPTH)) ? sr_q[a] : '0;

endmodule

// File: rtl/fifo_srl_af_stat.sv
// fifo_srl_af_stat: shift-register FIFO with registered almost-full
// back-pressure (grace window), true full guard, almost-empty flag,
// occupancy count and sticky overflow/underflow flags.
//   clk    - clock, everything on the rising edge
//   reset  - synchronous active-high reset
//   bus    - fifo_srl_af_stat_if.slave: write/read requests, head data and
//            status flags (see the interface for the signal list)
// The newest word sits at chain entry 0, so the oldest (head) word sits at
// entry cnt-1 and is read with an address derived from the count register.

module fifo_srl_af_stat
  import fifo_pkg::*;
#(
  parameter     MEM_STYLE    = "shiftreg",
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 16,
  parameter int GRACE_PERIOD = 2,
  parameter int AE_THRESH    = 1
) (
  input logic                clk,
  input logic                reset,
  fifo_srl_af_stat_if.slave  bus
);

  localparam int REAL_DEPTH = real_depth(DEPTH);
  localparam int CNT_WIDTH  = cnt_width(DEPTH);
  localparam int AW         = addr_width(DEPTH);

  `FIFO_CHECK(g_chk_grace, (GRACE_PERIOD >= 1) && (GRACE_PERIOD <= REAL_DEPTH - 2),
              "fifo_srl_af_stat: GRACE_PERIOD must be in 1..REAL_DEPTH-2")
  `FIFO_CHECK(g_chk_ae, (AE_THRESH >= 0) && (AE_THRESH < REAL_DEPTH),
              "fifo_srl_af_stat: AE_THRESH must be below REAL_DEPTH")

  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(REAL_DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_AF   = CNT_WIDTH'(REAL_DEPTH - GRACE_PERIOD);
  localparam logic [CNT_WIDTH-1:0] CNT_AE   = CNT_WIDTH'(AE_THRESH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  empty_n_q;
  logic                  af_q;
  logic                  ae_q;
  logic                  ovf_q;
  logic                  udf_q;

  logic                  full_i;
  logic                  empty_i;
  logic                  wr_req, wr;
  logic                  rd_req, rd;
  logic                  ovf_set, udf_set;
  logic [AW-1:0]         head_addr;
  logic [DATA_WIDTH-1:0] head_data;

  assign full_i  = (cnt_q == CNT_FULL);
  assign empty_i = (cnt_q == '0);

  assign wr_req = bus.if_write & bus.if_write_ce;
  assign rd_req = bus.if_read  & bus.if_read_ce;
  assign wr     = wr_req & ~full_i;
  assign rd     = rd_req & ~empty_i;

  // A write only counts as lost when no read frees a slot in the same cycle.
  assign ovf_set = wr_req & full_i & ~rd;
  // Symmetrically, a read issued to an empty FIFO together with a write is
  // just deferred (the write lands and the data is served next cycle), so
  // only a read with nothing to return is an underflow.
  assign udf_set = rd_req & empty_i & ~wr;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({wr, rd})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      empty_n_q <= 1'b0;
      af_q      <= 1'b0;
      ae_q      <= 1'b1;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      empty_n_q <= (cnt_d != '0);
      // Looks at the current count, not the next one: the flag trails the
      // occupancy by a cycle, and the grace window absorbs that lag.
      af_q      <= (cnt_q >= CNT_AF);
      ae_q      <= (cnt_d <= CNT_AE);
      if (ovf_set) ovf_q <= 1'b1;
      if (udf_set) udf_q <= 1'b1;
    end
  end

  // Head lives at entry cnt-1; when empty the address is a don't-care.
  assign head_addr = empty_i ? '0 : AW'(cnt_q - CNT_ONE);

  fifo_srl_af_stat_mem #(
    .MEM_STYLE (MEM_STYLE),
    .WIDTH     (DATA_WIDTH),
    .DEPTH     (REAL_DEPTH),
    .AW        (AW)
  ) u_mem (
    .clk  (clk),
    .ce   (wr & ~reset),
    .data (bus.if_din),
    .a    (head_addr),
    .q    (head_data)
  );

  assign bus.if_full_n       = ~af_q;
  assign bus.if_empty_n      = empty_n_q;
  assign bus.if_dout         = head_data;
  assign bus.if_almost_empty = ae_q;
  assign bus.if_count        = cnt_q;
  assign bus.if_overflow     = ovf_q;
  assign bus.if_underflow    = udf_q;

endmodule

// File: tb/tb_fifo_srl_af_stat.sv
// tb_fifo_srl_af_stat: directed scenarios followed by randomized traffic,
// every cycle compared against a queue-based model of the FIFO.

module tb_fifo_srl_af_stat;
  import fifo_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int GP    = 2;
  localparam int AE    = 1;
  localparam int RD    = (DEPTH < 4) ? 4 : DEPTH;
  localparam int CW    = $clog2(RD + 1);

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fifo_srl_af_stat_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus_if ();

  fifo_srl_af_stat #(
    .MEM_STYLE    ("shiftreg"),
    .DATA_WIDTH   (DW),
    .DEPTH        (DEPTH),
    .GRACE_PERIOD (GP),
    .AE_THRESH    (AE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  // Behavioural model: queue front = oldest word.
  logic [DW-1:0] mq[$];
  bit m_af  = 1'b0;
  bit m_ae  = 1'b1;
  bit m_ovf = 1'b0;
  bit m_udf = 1'b0;

  int n_vec = 0;
  int n_bad = 0;
  int cycle = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cycle, act, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit w, input bit wce,
                            input bit r, input bit rce, input logic [DW-1:0] d);
    bit wreq, rreq, acc_w, acc_r;
    int n;
    if (rst) begin
      mq.delete();
      m_af = 0; m_ae = 1; m_ovf = 0; m_udf = 0;
      return;
    end
    wreq  = w & wce;
    rreq  = r & rce;
    n     = mq.size();
    acc_w = wreq && (n < RD);
    acc_r = rreq && (n > 0);
    if (wreq && n == RD && !acc_r) m_ovf = 1;
    if (rreq && n == 0 && !acc_w)  m_udf = 1;
    m_af = (n >= RD - GP);
    if (acc_r) void'(mq.pop_front());
    if (acc_w) mq.push_back(d);
    m_ae = (mq.size() <= AE);
  endtask

  task automatic compare_all();
    chk("count",   bus_if.if_count, 64'(mq.size()));
    chk("empty_n", bus_if.if_empty_n, 64'(mq.size() != 0));
    chk("full_n",  bus_if.if_full_n, 64'(!m_af));
    chk("alm_emp", bus_if.if_almost_empty, 64'(m_ae));
    chk("ovf",     bus_if.if_overflow, 64'(m_ovf));
    chk("udf",     bus_if.if_underflow, 64'(m_udf));
    if (mq.size() != 0) chk("dout", bus_if.if_dout, 64'(mq[0]));
  endtask

  // One clock cycle: drive at the falling edge, model at the rising edge,
  // compare at the next falling edge.
  task automatic cyc(input bit rst, input bit w, input bit r, input logic [DW-1:0] d,
                     input bit wce = 1'b1, input bit rce = 1'b1);
    reset              = rst;
    bus_if.if_write    = w;
    bus_if.if_write_ce = wce;
    bus_if.if_read     = r;
    bus_if.if_read_ce  = rce;
    bus_if.if_din      = d;
    @(posedge clk);
    model_step(rst, w, wce, r, rce, d);
    @(negedge clk);
    cycle++;
    $display("cyc %0d rst=%0b wr=%0b/%0b rd=%0b/%0b din=%0h -> cnt=%0d empty_n=%0b full_n=%0b ae=%0b dout=%0h",
             cycle, rst, w, wce, r, rce, d, bus_if.if_count, bus_if.if_empty_n,
             bus_if.if_full_n, bus_if.if_almost_empty, bus_if.if_dout);
    compare_all();
  endtask

  initial begin
    bus_if.if_write    = 0;
    bus_if.if_write_ce = 0;
    bus_if.if_read     = 0;
    bus_if.if_read_ce  = 0;
    bus_if.if_din      = '0;
    @(negedge clk);

    // Reset then idle
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("rst_count",   bus_if.if_count, 0);
    chk("rst_empty_n", bus_if.if_empty_n, 0);
    chk("rst_full_n",  bus_if.if_full_n, 1);
    chk("rst_ae",      bus_if.if_almost_empty, 1);
    chk("rst_ovf",     bus_if.if_overflow, 0);
    chk("rst_udf",     bus_if.if_underflow, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
    chk("idle_count",  bus_if.if_count, 0);

    // Fill 0..15; almost-full shows up the edge after count reaches 14
    for (int i = 0; i < 16; i++) begin
      cyc(0, 1, 0, DW'(i));
      if (i == 13) chk("full_n_at_14", bus_if.if_full_n, 1);
      if (i == 14) chk("full_n_after_14", bus_if.if_full_n, 0);
    end
    chk("fill_count", bus_if.if_count, 16);
    chk("fill_ovf",   bus_if.if_overflow, 0);
    cyc(0, 1, 0, 32'hDEAD);
    chk("ovf_count",  bus_if.if_count, 16);
    chk("ovf_set",    bus_if.if_overflow, 1);

    // Drain order
    for (int i = 0; i < 16; i++) begin
      chk("drain_dout", bus_if.if_dout, 64'(i));
      cyc(0, 0, 1, 0);
      if (i == 13) chk("ae_at_2", bus_if.if_almost_empty, 0);
      if (i == 14) chk("ae_at_1", bus_if.if_almost_empty, 1);
    end
    chk("drain_empty_n", bus_if.if_empty_n, 0);

    // Simultaneous read/write at count 5
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, DW'(100 + i));
    for (int i = 0; i < 10; i++) cyc(0, 1, 1, DW'(200 + i));
    chk("rw5_count", bus_if.if_count, 5);
    chk("rw5_head",  bus_if.if_dout, 205);

    // Both at empty: only the write lands
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 32'h77);
    chk("rw0_count", bus_if.if_count, 1);
    chk("rw0_udf",   bus_if.if_underflow, 0);
    chk("rw0_dout",  bus_if.if_dout, 32'h77);

    // Both at full: only the read lands
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 16; i++) cyc(0, 1, 0, DW'(300 + i));
    cyc(0, 1, 1, 32'hBAD);
    chk("rw16_count", bus_if.if_count, 15);
    chk("rw16_ovf",   bus_if.if_overflow, 0);
    chk("rw16_head",  bus_if.if_dout, 301);

    // Underflow is sticky
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0);
    chk("udf_set", bus_if.if_underflow, 1);
    for (int i = 0; i < 20; i++) cyc(0, (i % 2) == 0, (i % 2) == 1, DW'(i));
    chk("udf_sticky", bus_if.if_underflow, 1);

    // Reset mid-stream at count 9, requests ignored in the reset cycle
    for (int i = 0; i < 9; i++) cyc(0, 1, 0, DW'(400 + i));
    chk("pre_rst_count", bus_if.if_count, 9);
    cyc(1, 1, 1, 32'h1234);
    chk("mid_rst_count",   bus_if.if_count, 0);
    chk("mid_rst_empty_n", bus_if.if_empty_n, 0);
    chk("mid_rst_full_n",  bus_if.if_full_n, 1);
    chk("mid_rst_ae",      bus_if.if_almost_empty, 1);
    chk("mid_rst_udf",     bus_if.if_underflow, 0);
    cyc(0, 1, 0, 32'hA5);
    chk("post_rst_dout",    bus_if.if_dout, 32'hA5);
    chk("post_rst_empty_n", bus_if.if_empty_n, 1);

    // Randomized traffic with phases biased toward filling and draining
    for (int seg = 0; seg < 16; seg++) begin
      int pw, pr;
      pw = (seg % 4 == 0) ? 90 : (seg % 4 == 1) ? 20 : (seg % 4 == 2) ? 60 : 50;
      pr = (seg % 4 == 0) ? 30 : (seg % 4 == 1) ? 90 : (seg % 4 == 2) ? 55 : 50;
      for (int k = 0; k < 100; k++) begin
        bit rst_r, w_r, r_r, wce_r, rce_r;
        rst_r = ($urandom_range(0, 299) == 0);
        w_r   = ($urandom_range(0, 99) < pw);
        r_r   = ($urandom_range(0, 99) < pr);
        wce_r = ($urandom_range(0, 9) != 0);
        rce_r = ($urandom_range(0, 9) != 0);
        cyc(rst_r, w_r, r_r, DW'($urandom), wce_r, rce_r);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
